// File: rtl/reset_request_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// reset_request_debouncer_pkg
//
// Shared definitions for the reset-request debouncer:
//   - deb_state_t    : debounce FSM state encoding
//   - DEFAULT_CNT_W  : default width of the debounce counter
//   - released_level : raw btn_in level that means "not pressed"
// ---------------------------------------------------------------------------
package reset_request_debouncer_pkg;

    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } deb_state_t;

    // An active-low button rests high, an active-high button rests low.
    function automatic logic released_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/reset_request_debouncer_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//
// Parameterised-depth flop synchroniser for asynchronous single-bit inputs
// (buttons, UART RX, ...). All stages load RESET_VAL on reset so the
// output starts at the input's idle level instead of producing a false edge.
//
// Parameters:
//   STAGES    : number of flops in series (>= 2)
//   RESET_VAL : value loaded into every stage on reset
// Ports:
//   clk   in  : sampling clock
//   reset in  : synchronous, active-high
//   d     in  : asynchronous input
//   q     out : synchronised output, STAGES cycles of latency
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/reset_request_debouncer.sv
// ---------------------------------------------------------------------------
// reset_request_debouncer
//
// Turns the raw board reset push-button into a clean reset request for the
// reset-stretching stage. The button is synchronised, normalised to
// "1 = pressed", and fed to a debounce FSM that only changes the accepted
// level after a run of consecutive stable samples.
//
// Optional feature (macro RESET_REQUEST_POR_EN): a power-on request holds
// req_out high during reset and for POR_CYCLES cycles afterwards, so the
// stretcher fires at start-up without a button press. Without the macro the
// counter is not built and req_out follows btn_level.
//
// Valid/ready: this block has no handshakes; every output is a plain level
// or a single-cycle strobe, registered on clk.
//
// Ports:
//   clk         in  : sole clock
//   reset       in  : synchronous, active-high
//   btn_in      in  : raw asynchronous button input
//   req_out     out : reset request level (btn_level OR power-on request)
//   btn_level   out : debounced pressed level, active-high
//   press_pulse out : one-cycle strobe aligned with btn_level rising
//   busy        out : high while a press or release is being qualified
//   dbg_state   out : current debounce FSM state
// ---------------------------------------------------------------------------
module reset_request_debouncer
    import reset_request_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned POR_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       req_out,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       busy,
    output deb_state_t dbg_state
);

    // Elaboration-time guards on the legal parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..2^CNT_W-1");
    end
    if (POR_CYCLES < 1) begin : g_bad_por
        $error("POR_CYCLES must be at least 1");
    end

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -----------------------------------------------------------------------
    // Synchroniser and polarity normalisation (s = 1 means pressed)
    // -----------------------------------------------------------------------
    logic sync_q;
    logic s;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (released_level(BTN_ACTIVE_LOW))
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync_q)
    );

    assign s = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

    // -----------------------------------------------------------------------
    // Debounce FSM
    // -----------------------------------------------------------------------
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            busy        <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRESS_CHK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DB_MAX) begin
                        state       <= ST_HELD;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        // cnt < DB_MAX here, so it can never pass DB_MAX.
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state <= ST_REL_CHK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_REL_CHK: begin
                    if (s) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DB_MAX) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // Level the FSM will hold after this edge; lets req_out be registered
    // in step with btn_level instead of lagging it by a cycle.
    logic level_nxt;

    always_comb begin
        level_nxt = btn_level;
        case (state)
            ST_PRESS_CHK: if (s && cnt == DB_MAX)  level_nxt = 1'b1;
            ST_REL_CHK:   if (!s && cnt == DB_MAX) level_nxt = 1'b0;
            default:      ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Power-on request
    // -----------------------------------------------------------------------
    logic req_reset_val;
    logic por_hold;

`ifdef RESET_REQUEST_POR_EN
    localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);

    logic [POR_W-1:0] por_cnt;

    // Loaded during reset, then counts down once per cycle and parks at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            por_cnt <= POR_W'(POR_CYCLES);
        end else if (por_cnt != '0) begin
            por_cnt <= por_cnt - POR_W'(1);
        end
    end

    // One post-reset cycle of request per remaining count.
    assign por_hold      = (por_cnt != '0);
    assign req_reset_val = 1'b1;
`else
    assign por_hold      = 1'b0;
    assign req_reset_val = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            req_out <= req_reset_val;
        end else begin
            req_out <= level_nxt | por_hold;
        end
    end

endmodule
